// File: rtl/jt49_bus_seq.sv
`default_nettype none
// ============================================================================
// Module      : jt49_bus_seq
// Description : Write sequencer and two-way arbiter for a shared BDIR/BC1 PSG
//               bus. Two requesters post (addr, data) register writes over
//               valid/ready. The writes are buffered in a 2^AW-entry FIFO and
//               replayed as a latch-address phase followed by a write phase,
//               which drives the bdir/bc1/din inputs of the jt49 bus wrapper.
//
// Ports       : clk        - system clock, all logic on posedge
//               rst_n      - synchronous active-low reset
//               req0_*     - requester 0 write request (valid/addr/data/ready)
//               req1_*     - requester 1 write request (valid/addr/data/ready)
//               bdir, bc1  - registered PSG bus control (never 01)
//               bus_dout   - registered PSG bus data to the wrapper din
//               busy       - registered: FIFO non-empty or sequencer active
//               level      - FIFO occupancy, 0..2^AW
//
// Parameters  : AW   - log2 of the FIFO depth
//               HOLD - cycles each active bus phase is held (legal 1..15)
//
// Revision    : 1.0 - initial release
// ============================================================================
module jt49_bus_seq #(
   parameter int AW   = 2,
   parameter int HOLD = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   input  logic [7:0]    req0_addr,
   input  logic [7:0]    req0_data,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [7:0]    req1_addr,
   input  logic [7:0]    req1_data,
   output logic          req1_ready,
   output logic          bdir,
   output logic          bc1,
   output logic [7:0]    bus_dout,
   output logic          busy,
   output logic [AW:0]   level
);

   localparam int            DEPTH    = 1 << AW;
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [3:0]    HOLD_LD  = 4'(HOLD);

   // Sequencer states
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_GAP1  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_GAP2  = 3'd4;

   // FIFO storage and bookkeeping
   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [AW:0]   count_q;
   logic [AW:0]   count_d;

   // Round-robin pointer: 0 -> requester 0 wins a tie, 1 -> requester 1 wins
   logic          rr_q;
   logic          rr_d;

   // Sequencer
   logic [2:0]    state_q;
   logic [2:0]    state_d;
   logic [3:0]    cnt_q;
   logic [3:0]    cnt_d;
   logic [7:0]    data_q;
   logic [7:0]    data_d;
   logic          bdir_q;
   logic          bdir_d;
   logic          bc1_q;
   logic          bc1_d;
   logic [7:0]    dout_q;
   logic [7:0]    dout_d;
   logic          busy_q;
   logic          busy_d;

   logic          fifo_empty;
   logic          fifo_full;
   logic          pop;
   logic          push;
   logic          gnt0;
   logic          gnt1;
   logic [15:0]   push_word;
   logic [15:0]   head;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == LVL_FULL);
   assign head       = mem_q[rptr_q];

   // The sequencer takes a new entry only from IDLE or from the trailing gap
   // of the previous write, so back-to-back writes skip the IDLE cycle.
   assign pop = ((state_q == S_IDLE) || (state_q == S_GAP2)) && !fifo_empty;

   // Arbitration. A pop in the same cycle frees a slot, so a full FIFO can
   // still accept one entry that cycle.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      rr_d = rr_q;
      if (!fifo_full || pop) begin
         if (req0_valid && (!req1_valid || !rr_q)) begin
            gnt0 = 1'b1;
            rr_d = 1'b1;
         end else if (req1_valid) begin
            gnt1 = 1'b1;
            rr_d = 1'b0;
         end
      end
   end

   assign push      = gnt0 | gnt1;
   assign push_word = gnt0 ? {req0_addr, req0_data} : {req1_addr, req1_data};

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + LVL_ONE;
         2'b01:   count_d = count_q - LVL_ONE;
         default: count_d = count_q;
      endcase
   end

   // Next-state and next-output logic; bus outputs are registered on entry
   // to each state so the bus changes exactly at state boundaries.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      bdir_d  = bdir_q;
      bc1_d   = bc1_q;
      dout_d  = dout_q;
      case (state_q)
         S_IDLE, S_GAP2: begin
            if (pop) begin
               state_d = S_ADDR;
               cnt_d   = HOLD_LD;
               data_d  = head[7:0];
               bdir_d  = 1'b1;
               bc1_d   = 1'b1;
               dout_d  = head[15:8];
            end else begin
               state_d = S_IDLE;
               bdir_d  = 1'b0;
               bc1_d   = 1'b0;
            end
         end
         S_ADDR: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_GAP1;
               bdir_d  = 1'b0;
               bc1_d   = 1'b0;
               dout_d  = data_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_GAP1: begin
            state_d = S_WRITE;
            cnt_d   = HOLD_LD;
            bdir_d  = 1'b1;
            bc1_d   = 1'b0;
            dout_d  = data_q;
         end
         S_WRITE: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_GAP2;
               bdir_d  = 1'b0;
               bc1_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            bdir_d  = 1'b0;
            bc1_d   = 1'b0;
         end
      endcase
   end

   assign busy_d = (count_d != '0) || (state_d != S_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         rr_q    <= 1'b0;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         bdir_q  <= 1'b0;
         bc1_q   <= 1'b0;
         dout_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + PTR_ONE;
         if (pop)  rptr_q <= rptr_q + PTR_ONE;
         count_q <= count_d;
         rr_q    <= rr_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         bdir_q  <= bdir_d;
         bc1_q   <= bc1_d;
         dout_q  <= dout_d;
         busy_q  <= busy_d;
      end
   end

   // Storage has no reset; entries are only visible through the pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= push_word;
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign bdir       = bdir_q;
   assign bc1        = bc1_q;
   assign bus_dout   = dout_q;
   assign busy       = busy_q;
   assign level      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_jt49_bus_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_jt49_bus_seq
// Description : Self-checking bench for jt49_bus_seq. A queue-based reference
//               model predicts grants, occupancy and the bus waveform each
//               cycle; granted writes go to a scoreboard that a separate
//               monitor drains as writes appear on the bus. A second instance
//               with HOLD=1 is checked against a fixed waveform table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jt49_bus_seq;

   localparam int HOLD_A = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       v0, v1;
   logic [7:0] a0, d0, a1, d1;
   logic       r0, r1, bdir, bc1, busy;
   logic [7:0] dout;
   logic [2:0] level;

   logic       bv0;
   logic [7:0] ba0, bd0;
   logic       br0, br1, bbdir, bbc1, bbusy;
   logic [7:0] bdout;
   logic [2:0] blevel;

   jt49_bus_seq #(.AW(2), .HOLD(HOLD_A)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
      .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
      .bdir(bdir), .bc1(bc1), .bus_dout(dout), .busy(busy), .level(level)
   );

   jt49_bus_seq #(.AW(2), .HOLD(1)) dut_h1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(bv0), .req0_addr(ba0), .req0_data(bd0), .req0_ready(br0),
      .req1_valid(1'b0), .req1_addr(8'h00), .req1_data(8'h00), .req1_ready(br1),
      .bdir(bbdir), .bc1(bbc1), .bus_dout(bdout), .busy(bbusy), .level(blevel)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model state
   logic [15:0] pend[$];    // writes waiting in the FIFO, {addr,data}
   logic [10:0] busq[$];    // upcoming bus cycles {check_dout, bdir, bc1, dout}
   logic [15:0] exp_q[$];   // scoreboard of granted writes, in grant order
   bit          rr;         // 0: requester 0 wins a tie
   logic        g0, g1;

   // Values seen this cycle, for directed checks
   logic       s_r0, s_r1;
   logic [1:0] s_bus;
   logic [2:0] s_level;

   // HOLD=1 instance expectations {busy, level[2:0], chk, bdir, bc1, dout}
   logic [14:0] btab [6];
   int          bi = -1;

   task automatic model_cycle();
      logic [10:0] e;
      logic [15:0] w;
      bit act, pop, can;
      int lvl;
      lvl = pend.size();
      act = (busq.size() != 0);
      e   = 11'h000;
      if (act) e = busq.pop_front();
      // A new write starts only once the previous one has fully played out.
      pop = (busq.size() == 0) && (lvl > 0);
      if (pop) begin
         w = pend.pop_front();
         repeat (HOLD_A) busq.push_back({1'b1, 2'b11, w[15:8]});
         busq.push_back({1'b1, 2'b00, w[7:0]});
         repeat (HOLD_A) busq.push_back({1'b1, 2'b10, w[7:0]});
         busq.push_back({1'b0, 2'b00, 8'h00});
      end
      can = (lvl < 4) || pop;
      g0  = can && v0 && (!v1 || !rr);
      g1  = can && v1 && !g0;
      if (g0) begin pend.push_back({a0, d0}); exp_q.push_back({a0, d0}); rr = 1'b1; end
      if (g1) begin pend.push_back({a1, d1}); exp_q.push_back({a1, d1}); rr = 1'b0; end
      if (rst_n) begin
         check("rdy0_rdy1_bus_level_busy", {r0, r1, bdir, bc1, level, busy},
               {g0, g1, e[9:8], 3'(lvl), (act || (lvl > 0))});
         if (e[10]) check("bus_dout", dout, e[7:0]);
      end else begin
         pend.delete();
         busq.delete();
         exp_q.delete();
         rr = 1'b0;
      end
   endtask

   task automatic b_check();
      logic [14:0] t;
      if (bi < 0) return;
      if (bi == 0) begin
         check("hold1_ready", {br0, br1}, 2'b10);
      end else begin
         t = btab[bi-1];
         check("hold1_busy_level_bus", {bbusy, blevel, bbdir, bbc1}, {t[14:11], t[9:8]});
         if (t[10]) check("hold1_dout", bdout, t[7:0]);
      end
      bi = (bi == 6) ? -1 : bi + 1;
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      b_check();
      s_r0    = r0;
      s_r1    = r1;
      s_bus   = {bdir, bc1};
      s_level = level;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      v0 = 1'b0; v1 = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int k;
      k = 0;
      v0 = 1'b0; v1 = 1'b0;
      while ((pend.size() != 0 || busq.size() != 0) && k < 300) begin
         step();
         k++;
      end
      if (k >= 300) check("drain_timeout", 1, 0);
      step();
   endtask

   // Monitor: each WRITE phase completes one write; compare against the
   // oldest outstanding grant.
   initial begin
      logic [1:0]  prev;
      logic [7:0]  la;
      logic [15:0] e;
      prev = 2'b00;
      la   = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 2'b00;
         end else begin
            if ({bdir, bc1} == 2'b11) la = dout;
            if ({bdir, bc1} == 2'b10 && prev != 2'b10) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_write", {la, dout}, 17'h10000);
               end else begin
                  e = exp_q.pop_front();
                  check("write_order", {la, dout}, e);
               end
            end
            prev = {bdir, bc1};
         end
      end
   end

   initial begin
      int nxt, first11, last10, lvl_max, grants;
      v0 = 0; v1 = 0; a0 = 0; d0 = 0; a1 = 0; d1 = 0;
      bv0 = 0; ba0 = 0; bd0 = 0;
      rst_n = 1'b0;
      rr = 1'b0;
      #1;
      do_reset();
      step();

      // Single write
      v0 = 1'b1; a0 = 8'h07; d0 = 8'h38;
      step();
      check("single_ready", s_r0, 1'b1);
      drain();

      // Contention: alternation must start with requester 0 after reset
      do_reset();
      v0 = 1'b1; v1 = 1'b1;
      a0 = 8'($urandom); d0 = 8'h01;
      a1 = 8'($urandom); d1 = 8'h81;
      nxt = 0;
      repeat (40) begin
         step();
         if (s_r0 | s_r1) begin
            check("contention_alternate", s_r1, nxt[0]);
            nxt ^= 1;
         end
         if (g0) begin d0 = d0 + 8'd1; a0 = 8'($urandom); end
         if (g1) begin d1 = d1 + 8'd1; a1 = 8'($urandom); end
      end
      drain();

      // Full FIFO: requester 0 always valid, incrementing address
      v0 = 1'b1; a0 = 8'h00; d0 = 8'($urandom);
      lvl_max = 0;
      repeat (45) begin
         step();
         if (int'(s_level) > lvl_max) lvl_max = int'(s_level);
         if (g0) begin a0 = a0 + 8'd1; d0 = 8'($urandom); end
      end
      check("full_level_max", lvl_max, 4);
      drain();

      // Back-to-back: first ADDR to last WRITE cycle spans 2*(2*HOLD+2)-1
      v0 = 1'b1; a0 = 8'h03; d0 = 8'hA5;
      step();
      v0 = 1'b0; v1 = 1'b1; a1 = 8'h04; d1 = 8'h5A;
      step();
      v1 = 1'b0;
      first11 = -1; last10 = -1;
      for (int c = 0; c < 20; c++) begin
         step();
         if (s_bus == 2'b11 && first11 < 0) first11 = c;
         if (s_bus == 2'b10) last10 = c;
      end
      check("b2b_span", last10 - first11 + 1, 11);
      drain();

      // Reset during the WRITE phase with three entries still queued
      do_reset();
      v0 = 1'b1;
      grants = 0;
      while (grants < 4) begin
         a0 = 8'($urandom); d0 = 8'($urandom);
         step();
         if (g0) grants++;
      end
      v0 = 1'b0;
      begin
         int k;
         k = 0;
         while (s_bus != 2'b10 && k < 50) begin step(); k++; end
         check("reach_write_phase", (k < 50), 1'b1);
      end
      check("queued_at_reset", pend.size(), 3);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check("post_reset_bus_level_busy", {s_bus, s_level, busy}, 6'b0);
      v1 = 1'b1; a1 = 8'h0B; d1 = 8'hC3;
      step();
      check("post_reset_req1_ready", s_r1, 1'b1);
      drain();

      // HOLD=1 instance: 11, 00, 10, 00 then idle
      btab[0] = {1'b1, 3'd1, 1'b0, 2'b00, 8'h00};
      btab[1] = {1'b1, 3'd0, 1'b1, 2'b11, 8'h0A};
      btab[2] = {1'b1, 3'd0, 1'b1, 2'b00, 8'h5C};
      btab[3] = {1'b1, 3'd0, 1'b1, 2'b10, 8'h5C};
      btab[4] = {1'b1, 3'd0, 1'b0, 2'b00, 8'h00};
      btab[5] = {1'b0, 3'd0, 1'b0, 2'b00, 8'h00};
      bv0 = 1'b1; ba0 = 8'h0A; bd0 = 8'h5C; bi = 0;
      step();
      bv0 = 1'b0;
      repeat (7) step();

      // Randomized traffic
      repeat (400) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         a0 = 8'($urandom); d0 = 8'($urandom);
         a1 = 8'($urandom); d1 = 8'($urandom);
         step();
      end
      drain();
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jt49_bus_seq.md
Name: jt49_bus_seq

Overview:
- Write sequencer and arbiter that shares one BDIR/BC1 PSG bus interface between two register-write requesters, e.g. the main CPU and a sound driver or debug port.
- Accepts (addr, data) write requests over valid/ready and buffers them in a small FIFO.
- Replays each buffered write as a latch-address phase followed by a write phase, matching the bus protocol of the jt49 bus wrapper.
- Sits directly in front of the PSG bus wrapper and drives its bdir, bc1 and din.

Parameters:
- AW, 2, log2 of FIFO depth (depth = 2^AW = 4 entries).
- HOLD, 2, clk cycles each active bus phase (ADDR, WRITE) is held; legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  8  requester 0 register address
- req0_data  input  8  requester 0 register data
- req0_ready  output  1  requester 0 accepted this cycle (combinational grant)
- req1_valid  input  1  requester 1 has a write pending
- req1_addr  input  8  requester 1 register address
- req1_data  input  8  requester 1 register data
- req1_ready  output  1  requester 1 accepted this cycle
- bdir  output  1  PSG bus BDIR, registered
- bc1  output  1  PSG bus BC1, registered
- bus_dout  output  8  PSG bus data to the wrapper din, registered
- busy  output  1  FIFO non-empty or FSM not IDLE
- level  output  AW+1  FIFO occupancy, 0..2^AW

Behaviour:
- Reset (synchronous, rst_n low at posedge):
  - bdir=0, bc1=0, bus_dout=0.
  - FSM=IDLE, FIFO emptied (level=0), round-robin pointer=req0.
  - Reset mid-sequence aborts the current write; the partial write is lost and the bus returns to 00 on the next cycle.
- Arbitration:
  - A grant is issued in a cycle only when the FIFO is not full, or when a pop occurs in the same cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester named by the pointer is granted; the pointer then moves to the other requester.
  - A single-requester grant sets the pointer to the non-granted requester.
  - At most one grant per cycle; readyX is asserted only when validX is high.
  - The granted entry is written into the FIFO at that posedge.
- FIFO:
  - 2^AW entries, 16 bits each ({addr, data}).
  - Simultaneous push and pop when full is allowed; level is unchanged.
  - Pointers wrap modulo 2^AW.
  - No push when full without a pop; no pop when empty.
- FSM, with outputs registered on entry to each state:
  - IDLE: {bdir,bc1}=00. If FIFO non-empty: pop, go to ADDR.
  - ADDR: {bdir,bc1}=11, bus_dout=addr, held HOLD cycles, then go to GAP1.
  - GAP1: {bdir,bc1}=00, bus_dout=data, 1 cycle, then go to WRITE.
  - WRITE: {bdir,bc1}=10, bus_dout=data, held HOLD cycles, then go to GAP2.
  - GAP2: {bdir,bc1}=00, 1 cycle. If FIFO non-empty, pop and go directly to ADDR; otherwise go to IDLE.
  - A 4-bit phase counter counts HOLD down; it is reloaded on entry to ADDR and WRITE.
- Timing:
  - Latency: a request granted in cycle T with an empty FIFO and the FSM in IDLE shows bdir/bc1=11 from cycle T+2.
  - Throughput: back-to-back writes take 2*HOLD+2 cycles each.
  - The bus never shows 01 (read).
  - 11 and 10 are always separated by at least one 00 cycle.
- Address: all 8 bits are passed unchanged; the wrapper ignores addresses 0x10 and above, so no filtering is done here.
- busy is registered and updates with the FSM and FIFO state.

Test Plan:
- Single write: reset, HOLD=2, req0 {0x07,0x38} for one cycle.
  - req0_ready=1 that cycle.
  - From T+2: bus shows 11/0x07 for 2 cycles, then 00, then 10/0x38 for 2 cycles, then 00, then IDLE.
  - busy falls after the sequence; the wrapper's register 7 reads 0x38.
- Contention: req0 and req1 both valid continuously, each with distinct data (0x01.., 0x81..).
  - Grants alternate 0,1,0,1 starting with req0.
  - Bus write order matches grant order.
- Full FIFO: req0 valid every cycle with an incrementing address.
  - level reaches 4 and req0_ready deasserts.
  - Thereafter one grant per pop, every 6 cycles.
  - No entry is lost or duplicated.
- Back-to-back: two queued writes.
  - GAP2 is followed directly by ADDR with no IDLE cycle.
  - Total 12 cycles for both writes with HOLD=2.
- Reset mid-operation: assert rst_n low during the WRITE phase with 3 entries queued.
  - Next cycle: bus 00, level=0, busy=0.
  - After release, a new req1 write proceeds normally and req1 is not starved.
- HOLD=1: a single write completes in 4 bus cycles: 11, 00, 10, 00.
